// File: rtl/irq_encoder8_to_3.sv
// Sticky 8-source interrupt encoder: latches request lines into pending flags and
// presents the highest-priority eligible source as a held 3-bit code until acknowledged.
module irq_encoder8_to_3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       en,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending
);

  // Handshake: once valid=1, code is frozen until an edge with ack=1; that edge
  // retires the code, drops valid, and the next code can appear one edge later.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] eligible;
  logic [2:0] top_idx;
  logic       any_eligible;
  logic [7:0] clr;

  assign eligible     = pending & mask;
  assign any_eligible = |eligible;

  // Ascending scan so the highest set index is the one left standing.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) top_idx = 3'(i);
    end
  end

  always_comb begin
    clr = 8'h00;
    if (state == PRESENT && ack) clr[code] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= 1'b0;
      code    <= 3'b000;
      pending <= 8'h00;
    end else begin
      // A request on the acknowledge edge re-arms its flag: set wins over clear.
      pending <= (pending & ~clr) | req;
      case (state)
        IDLE: begin
          if (en && any_eligible) begin
            code  <= top_idx;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_encoder8_to_3.sv
// Bench for irq_encoder8_to_3: directed scenarios plus random traffic, checked by a
// reference model feeding an expected-code queue drained by a monitor.
module tb_irq_encoder8_to_3;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       en;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;

  int tests;
  int fails;

  logic [2:0] exp_q[$];

  // Reference model state
  logic [7:0] m_pend;
  bit         m_busy;
  int         m_code;

  irq_encoder8_to_3 dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mask    (mask),
    .en      (en),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .pending (pending)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic model_clear();
    m_pend = 8'h00;
    m_busy = 0;
    m_code = 0;
    exp_q.delete();
  endtask

  // Drive one clock of inputs and advance the model across the following edge.
  task automatic cycle(input logic [7:0] r, input logic [7:0] m, input logic e, input logic a);
    logic [7:0] n_pend;
    bit         n_busy;
    int         n_code;
    bit         push;
    @(negedge clk);
    req = r; mask = m; en = e; ack = a;
    n_pend = m_pend;
    n_busy = m_busy;
    n_code = m_code;
    push   = 0;
    if (m_busy) begin
      if (a) begin
        n_pend[m_code] = 1'b0;
        n_busy = 0;
      end
    end else if (e) begin
      for (int i = 7; i >= 0; i--) begin
        if (m_pend[i] && m[i]) begin
          n_code = i;
          n_busy = 1;
          push   = 1;
          break;
        end
      end
    end
    n_pend = n_pend | r;
    @(posedge clk);
    m_pend = n_pend;
    m_busy = n_busy;
    m_code = n_code;
    if (push) exp_q.push_back(3'(n_code));
  endtask

  task automatic idle_cycles(input int n, input logic [7:0] m);
    for (int i = 0; i < n; i++) cycle(8'h00, m, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 8'h00; mask = 8'h00; en = 1'b0; ack = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit         prev_valid;
    logic [2:0] held;
    prev_valid = 0;
    held = 3'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0;
      end else begin
        chk("pending", int'(pending), int'(m_pend));
        chk("valid", int'(valid), int'(m_busy));
        if (valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL code_unexpected: got %0d expected none at %0t", code, $time);
          end else begin
            held = exp_q.pop_front();
            chk("code_new", int'(code), int'(held));
          end
        end else if (valid && prev_valid) begin
          chk("code_held", int'(code), int'(held));
        end
        prev_valid = valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req = 8'h00; mask = 8'h00; en = 1'b0; ack = 1'b0;
    model_clear();
    #2;
    chk("reset_valid", int'(valid), 0);
    chk("reset_code", int'(code), 0);
    chk("reset_pending", int'(pending), 0);
    do_reset();

    // Single pulse on source 5
    cycle(8'h20, 8'hFF, 1'b1, 1'b0);
    #1 chk("s26_pending", int'(pending), 8'h20);
    chk("s26_valid_early", int'(valid), 0);
    cycle(8'h00, 8'hFF, 1'b1, 1'b0);
    #1 chk("s26_code", int'(code), 5);
    cycle(8'h00, 8'hFF, 1'b1, 1'b1);
    #1 chk("s26_cleared", int'(pending), 8'h00);
    idle_cycles(2, 8'hFF);

    // Two sources: 3 before 1, with an idle gap between
    cycle(8'h0A, 8'hFF, 1'b1, 1'b0);
    idle_cycles(2, 8'hFF);
    cycle(8'h00, 8'hFF, 1'b1, 1'b1);
    #1 chk("s27_gap", int'(valid), 0);
    idle_cycles(2, 8'hFF);
    cycle(8'h00, 8'hFF, 1'b1, 1'b1);
    idle_cycles(2, 8'hFF);

    // Higher priority arrival while presenting does not preempt
    cycle(8'h04, 8'hFF, 1'b1, 1'b0);
    idle_cycles(1, 8'hFF);
    cycle(8'h80, 8'hFF, 1'b1, 1'b0);
    idle_cycles(3, 8'hFF);
    #1 chk("s28_hold", int'(code), 2);
    cycle(8'h00, 8'hFF, 1'b1, 1'b1);
    idle_cycles(2, 8'hFF);
    #1 chk("s28_next", int'(code), 7);
    cycle(8'h00, 8'hFF, 1'b1, 1'b1);
    idle_cycles(2, 8'hFF);

    // Masked source waits until unmasked
    cycle(8'h40, 8'h00, 1'b1, 1'b0);
    idle_cycles(10, 8'h00);
    #1 chk("s29_masked", int'(valid), 0);
    cycle(8'h00, 8'h40, 1'b1, 1'b0);
    #1 chk("s29_code", int'(code), 6);
    cycle(8'h00, 8'hFF, 1'b1, 1'b1);
    idle_cycles(2, 8'hFF);

    // Re-request on the acknowledge edge keeps the flag
    cycle(8'h10, 8'hFF, 1'b1, 1'b0);
    idle_cycles(2, 8'hFF);
    cycle(8'h10, 8'hFF, 1'b1, 1'b1);
    #1 chk("s30_sticky", int'(pending), 8'h10);
    idle_cycles(1, 8'hFF);
    #1 chk("s30_again", int'(valid), 1);
    cycle(8'h00, 8'hFF, 1'b1, 1'b1);
    idle_cycles(2, 8'hFF);

    // Asynchronous reset while presenting
    cycle(8'h08, 8'hFF, 1'b1, 1'b0);
    idle_cycles(2, 8'hFF);
    #2 rst = 1'b1;
    #1;
    chk("s31_valid", int'(valid), 0);
    chk("s31_code", int'(code), 0);
    chk("s31_pending", int'(pending), 0);
    req = 8'h00; mask = 8'h00; en = 1'b0; ack = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      logic [7:0] m;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
      cycle(r, m, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) == 0));
    end

    // Drain everything still pending
    for (int n = 0; n < 40; n++) cycle(8'h00, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    #1 chk("drain_queue", exp_q.size(), 0);
    chk("drain_pending", int'(pending), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
